// File: rtl/approx_adder_pkg.sv
// Shared definitions for the approximate-adder monitor: mode encoding and
// the width of sums/errors derived from the operand width.
package approx_adder_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  function automatic int unsigned err_width(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/approx_adder_monitor_if.sv
// Operand/result handshake bundle between a producer/consumer (master)
// and the adder monitor (slave).
interface approx_adder_monitor_if #(
    parameter int WIDTH = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic             mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   out0;
    logic             err_flag;

    modport master (
        output in_valid, in0, in1, mode, out_ready,
        input  in_ready, out_valid, out0, err_flag
    );

    modport slave (
        input  in_valid, in0, in1, mode, out_ready,
        output in_ready, out_valid, out0, err_flag
    );
endinterface

// File: rtl/approx_adder_monitor_core.sv
// Combinational lower-part-OR adder: low APPROX_BITS bits are OR-ed and the
// upper part receives the AND of the top approximated bits as its carry-in.
module loa_adder_core
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int APPROX_BITS = 1
) (
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             mode,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] exact;

    assign exact = {1'b0, in0} + {1'b0, in1};

    if (APPROX_BITS == 0) begin : g_exact
        // Nothing approximated: both modes produce the exact sum.
        assign sum = (mode == MODE_APPROX) ? exact : exact;
    end else begin : g_loa
        localparam int UW = WIDTH - APPROX_BITS;

        logic [APPROX_BITS-1:0] lo;
        logic                   carry;
        logic [UW:0]            hi;

        always_comb begin
            lo    = in0[APPROX_BITS-1:0] | in1[APPROX_BITS-1:0];
            carry = in0[APPROX_BITS-1] & in1[APPROX_BITS-1];
            hi    = {1'b0, in0[WIDTH-1:APPROX_BITS]} + {1'b0, in1[WIDTH-1:APPROX_BITS]}
                  + {{UW{1'b0}}, carry};
        end

        assign sum = (mode == MODE_APPROX) ? {hi, lo} : exact;
    end

endmodule

// File: rtl/approx_adder_monitor.sv
// Two-stage valid/ready pipeline around the LOA adder that tracks the error
// against the exact sum, counts threshold violations and keeps the max error.
module approx_adder_monitor
    import approx_adder_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int APPROX_BITS = 1,
    parameter int ET          = 5,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    approx_adder_monitor_if.slave  bus,
    input  logic                   clr,
    output logic [CNT_W-1:0]       viol_cnt,
    output logic [WIDTH:0]         max_err
);

    localparam int unsigned EW   = err_width(WIDTH);
    localparam int unsigned ET_U = ET;

    logic             s1_vld_q, s1_vld_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic             mode_q, mode_d;
    logic             s2_vld_q, s2_vld_d;
    logic [EW-1:0]    out0_q, out0_d, exact_q, exact_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]    max_q, max_d;

    logic [EW-1:0]    sum_apx, sum_exact, err;
    logic             s2_free, in_ready, accept, hs_out, err_flag;

    loa_adder_core #(
        .WIDTH      (WIDTH),
        .APPROX_BITS(APPROX_BITS)
    ) u_core (
        .in0 (a_q),
        .in1 (b_q),
        .mode(mode_q),
        .sum (sum_apx)
    );

    assign sum_exact = {1'b0, a_q} + {1'b0, b_q};

    always_comb begin
        err      = (exact_q >= out0_q) ? (exact_q - out0_q) : (out0_q - exact_q);
        err_flag = s2_vld_q && (32'(err) > ET_U);
    end

    // Stage 2 frees up when empty or draining; stage 1 follows stage 2.
    always_comb begin
        s2_free  = !s2_vld_q || bus.out_ready;
        in_ready = !s1_vld_q || s2_free;
        accept   = bus.in_valid && in_ready;
        hs_out   = s2_vld_q && bus.out_ready;

        s1_vld_d = s1_vld_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        s2_vld_d = s2_vld_q;
        out0_d   = out0_q;
        exact_d  = exact_q;
        cnt_d    = cnt_q;
        max_d    = max_q;

        if (in_ready) begin
            s1_vld_d = accept;
            if (accept) begin
                a_d    = bus.in0;
                b_d    = bus.in1;
                mode_d = bus.mode;
            end
        end

        if (s2_free) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                out0_d  = sum_apx;
                exact_d = sum_exact;
            end
        end

        if (clr) begin
            cnt_d = '0;
            max_d = '0;
        end else if (hs_out) begin
            if (err_flag && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
            if (err > max_q) max_d = err;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            s2_vld_q <= 1'b0;
            out0_q   <= '0;
            exact_q  <= '0;
            cnt_q    <= '0;
            max_q    <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            s2_vld_q <= s2_vld_d;
            out0_q   <= out0_d;
            exact_q  <= exact_d;
            cnt_q    <= cnt_d;
            max_q    <= max_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_vld_q;
    assign bus.out0      = out0_q;
    assign bus.err_flag  = err_flag;
    assign viol_cnt      = cnt_q;
    assign max_err       = max_q;

endmodule

// File: tb/tb_approx_adder_monitor.sv
// Bench for approx_adder_monitor: directed table and sequences on a 2-bit
// instance, exhaustive and random streams on 4-bit instances with a model.
module tb_approx_adder_monitor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    approx_adder_monitor_if #(.WIDTH(2)) ifa ();
    approx_adder_monitor_if #(.WIDTH(4)) ifb ();
    approx_adder_monitor_if #(.WIDTH(4)) ifc ();

    logic        clr_a, clr_b;
    logic [1:0]  cnt_a;
    logic [2:0]  max_a;
    logic [15:0] cnt_b, cnt_c;
    logic [4:0]  max_b, max_c;

    approx_adder_monitor #(.WIDTH(2), .APPROX_BITS(1), .ET(0), .CNT_W(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa), .clr(clr_a), .viol_cnt(cnt_a), .max_err(max_a));
    approx_adder_monitor #(.WIDTH(4), .APPROX_BITS(2), .ET(5), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb), .clr(clr_b), .viol_cnt(cnt_b), .max_err(max_b));
    approx_adder_monitor #(.WIDTH(4), .APPROX_BITS(0), .ET(0), .CNT_W(16)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc), .clr(clr_b), .viol_cnt(cnt_c), .max_err(max_c));

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference sum straight from the lower-part-OR definition.
    function automatic int ref_sum(input int ab, input int x, input int y, input bit m);
        int lm, lower, carry, upper;
        if (!m || ab == 0) return x + y;
        lm    = (1 << ab) - 1;
        lower = (x & lm) | (y & lm);
        carry = ((x >> (ab - 1)) & 1) & ((y >> (ab - 1)) & 1);
        upper = (x >> ab) + (y >> ab) + carry;
        return (upper << ab) + lower;
    endfunction

    typedef struct {
        bit m;
        int x;
        int y;
        int exp_out;
        bit exp_flag;
    } vec_t;

    typedef struct {
        int sum;
        int flag;
        int err;
        int ex;
    } exp_t;

    exp_t sbq[$];
    int   mv_cnt = 0;
    int   mv_max = 0;

    task automatic xact_a(input bit m, input int x, input int y,
                          output int o, output int f, output int lat);
        @(negedge clk);
        ifa.mode = m; ifa.in0 = x[1:0]; ifa.in1 = y[1:0];
        ifa.in_valid = 1'b1; ifa.out_ready = 1'b1;
        #1 chk("a_in_ready", ifa.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        ifa.in_valid = 1'b0;
        lat = 0;
        while (!ifa.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (!ifa.out_valid) chk("a_timeout", 0, 1);
        o = ifa.out0;
        f = ifa.err_flag;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_b(input bit v, input bit m, input int x, input int y, input bit rdy);
        ifb.in_valid = v; ifb.mode = m; ifb.in0 = x[3:0]; ifb.in1 = y[3:0]; ifb.out_ready = rdy;
        ifc.in_valid = v; ifc.mode = m; ifc.in0 = x[3:0]; ifc.in1 = y[3:0]; ifc.out_ready = rdy;
    endtask

    task automatic stream_b(input int n, input bit sweep, input int rdy_pct);
        int   sent = 0, got = 0, cyc = 0, x = 0, y = 0, s;
        bit   m = 1'b0, have = 1'b0, rdy;
        exp_t e;
        while (got < n && cyc < n * 4 + 50) begin
            @(negedge clk);
            cyc++;
            if (!have && sent < n) begin
                if (sweep) begin
                    m = (sent / 256) != 0; x = (sent / 16) % 16; y = sent % 16;
                end else begin
                    m = $urandom_range(1) != 0; x = $urandom_range(15); y = $urandom_range(15);
                end
                have = 1'b1;
            end
            rdy = $urandom_range(99) < rdy_pct;
            drive_b(have, m, x, y, rdy);
            #1;
            if (ifb.out_valid && ifb.out_ready) begin
                if (sbq.size() == 0) chk("b_spurious_result", 1, 0);
                else begin
                    e = sbq.pop_front();
                    chk("b_out0", ifb.out0, e.sum);
                    chk("b_err_flag", ifb.err_flag, e.flag);
                    chk("c_out0_exact", ifc.out0, e.ex);
                    chk("c_err_flag", ifc.err_flag, 0);
                    if (e.flag != 0 && mv_cnt < 65535) mv_cnt++;
                    if (e.err > mv_max) mv_max = e.err;
                    got++;
                end
            end
            if (have && ifb.in_ready) begin
                s = ref_sum(2, x, y, m);
                e.sum  = s;
                e.ex   = x + y;
                e.err  = (s > x + y) ? s - (x + y) : (x + y) - s;
                e.flag = (e.err > 5) ? 1 : 0;
                sbq.push_back(e);
                sent++;
                have = 1'b0;
            end
        end
        @(negedge clk);
        drive_b(1'b0, 1'b0, 0, 0, 1'b1);
        chk("b_delivered", got, n);
    endtask

    vec_t tbl[9];
    int   o, f, lat;
    bit   leak;

    initial begin
        tbl[0] = '{1'b1, 0, 0, 0, 1'b0};
        tbl[1] = '{1'b1, 1, 1, 3, 1'b1};
        tbl[2] = '{1'b1, 2, 3, 5, 1'b0};
        tbl[3] = '{1'b1, 3, 3, 7, 1'b1};
        tbl[4] = '{1'b1, 3, 1, 5, 1'b1};
        tbl[5] = '{1'b1, 2, 2, 4, 1'b0};
        tbl[6] = '{1'b0, 3, 3, 6, 1'b0};
        tbl[7] = '{1'b0, 1, 1, 2, 1'b0};
        tbl[8] = '{1'b0, 3, 2, 5, 1'b0};

        rst = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        ifa.in_valid = 1'b0; ifa.mode = 1'b0; ifa.in0 = '0; ifa.in1 = '0; ifa.out_ready = 1'b1;
        drive_b(1'b0, 1'b0, 0, 0, 1'b1);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", ifa.out_valid, 0);
        chk("rst_in_ready", ifa.in_ready, 1);
        chk("rst_out0", ifa.out0, 0);
        chk("rst_err_flag", ifa.err_flag, 0);
        chk("rst_viol_cnt", cnt_a, 0);
        chk("rst_max_err", max_a, 0);
        rst = 1'b0;

        xact_a(1'b1, 1, 1, o, f, lat);
        chk("approx11_out0", o, 3);
        chk("approx11_flag", f, 1);
        chk("approx11_latency", lat, 1);
        chk("approx11_viol_cnt", cnt_a, 1);
        chk("approx11_max_err", max_a, 1);

        xact_a(1'b0, 3, 3, o, f, lat);
        chk("exact33_out0", o, 6);
        chk("exact33_flag", f, 0);
        chk("exact33_viol_cnt", cnt_a, 1);
        chk("exact33_max_err", max_a, 1);

        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        chk("clr_viol_cnt", cnt_a, 0);
        chk("clr_max_err", max_a, 0);

        for (int i = 0; i < 9; i++) begin
            xact_a(tbl[i].m, tbl[i].x, tbl[i].y, o, f, lat);
            chk($sformatf("tbl%0d_out0", i), o, tbl[i].exp_out);
            chk($sformatf("tbl%0d_flag", i), f, tbl[i].exp_flag);
        end
        chk("tbl_viol_cnt", cnt_a, 3);
        chk("tbl_max_err", max_a, 1);

        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        for (int i = 0; i < 5; i++) xact_a(1'b1, 3, 3, o, f, lat);
        chk("sat_viol_cnt", cnt_a, 3);
        chk("sat_max_err", max_a, 1);
        @(negedge clk); clr_a = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        chk("sat_clr_viol_cnt", cnt_a, 0);
        chk("sat_clr_max_err", max_a, 0);

        // clr coinciding with a violating handshake
        @(negedge clk);
        ifa.out_ready = 1'b0; ifa.mode = 1'b1; ifa.in0 = 2'd1; ifa.in1 = 2'd1; ifa.in_valid = 1'b1;
        @(negedge clk); ifa.in_valid = 1'b0;
        @(negedge clk);
        chk("clrhs_out_valid", ifa.out_valid, 1);
        chk("clrhs_flag", ifa.err_flag, 1);
        clr_a = 1'b1; ifa.out_ready = 1'b1;
        @(negedge clk); clr_a = 1'b0;
        chk("clrhs_viol_cnt", cnt_a, 0);
        chk("clrhs_max_err", max_a, 0);
        chk("clrhs_drained", ifa.out_valid, 0);

        // back-to-back with stalled consumer
        @(negedge clk);
        ifa.out_ready = 1'b0; ifa.mode = 1'b0; ifa.in0 = 2'd1; ifa.in1 = 2'd2; ifa.in_valid = 1'b1;
        #1 chk("b2b_ready0", ifa.in_ready, 1);
        @(negedge clk); ifa.in0 = 2'd3; ifa.in1 = 2'd1;
        #1 chk("b2b_ready1", ifa.in_ready, 1);
        @(negedge clk); ifa.in0 = 2'd2; ifa.in1 = 2'd3;
        #1 chk("b2b_full_ready", ifa.in_ready, 0);
        chk("b2b_stall_valid", ifa.out_valid, 1);
        chk("b2b_stall_out0_a", ifa.out0, 3);
        @(negedge clk);
        #1 chk("b2b_stall_out0_b", ifa.out0, 3);
        chk("b2b_stall_ready", ifa.in_ready, 0);
        @(negedge clk);
        #1 chk("b2b_stall_out0_c", ifa.out0, 3);
        ifa.out_ready = 1'b1;
        #1 chk("b2b_resume_ready", ifa.in_ready, 1);
        @(negedge clk); ifa.in_valid = 1'b0;
        #1 chk("b2b_r1_valid", ifa.out_valid, 1);
        chk("b2b_r1_out0", ifa.out0, 4);
        @(negedge clk);
        #1 chk("b2b_r2_valid", ifa.out_valid, 1);
        chk("b2b_r2_out0", ifa.out0, 5);
        @(negedge clk);
        #1 chk("b2b_no_dup", ifa.out_valid, 0);

        stream_b(512, 1'b1, 100);
        stream_b(300, 1'b0, 60);
        chk("b_viol_cnt", cnt_b, mv_cnt);
        chk("b_max_err", max_b, mv_max);
        chk("c_viol_cnt", cnt_c, 0);
        chk("c_max_err", max_c, 0);

        // reset with both stages full
        xact_a(1'b1, 1, 1, o, f, lat);
        chk("prerst_viol_cnt", cnt_a, 1);
        @(negedge clk);
        ifa.out_ready = 1'b0; ifa.mode = 1'b0; ifa.in0 = 2'd1; ifa.in1 = 2'd1; ifa.in_valid = 1'b1;
        @(negedge clk); ifa.in0 = 2'd2; ifa.in1 = 2'd1;
        #1 chk("fill_ready", ifa.in_ready, 1);
        @(negedge clk); ifa.in_valid = 1'b0;
        #1 chk("fill_valid", ifa.out_valid, 1);
        chk("fill_full", ifa.in_ready, 0);
        #2 rst = 1'b1;
        #1 chk("arst_out_valid", ifa.out_valid, 0);
        chk("arst_viol_cnt", cnt_a, 0);
        chk("arst_max_err", max_a, 0);
        chk("arst_out0", ifa.out0, 0);
        chk("arst_in_ready", ifa.in_ready, 1);
        @(negedge clk); rst = 1'b0; ifa.out_ready = 1'b1;
        leak = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.out_valid) leak = 1'b1;
        end
        chk("postrst_no_result", leak, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/approx_adder_monitor.md
APPROX_ADDER_MONITOR -- requirements
Module: approx_adder_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 2, operand width in bits (>=2).
REQ-002 SHALL have parameter APPROX_BITS, default 1, number of low sum bits approximated (0..WIDTH-1).
REQ-003 SHALL have parameter ET, default 5, error threshold; absolute error strictly above ET is a violation.
REQ-004 SHALL have parameter CNT_W, default 16, violation counter width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have: in_valid  input  1  operand pair valid.
REQ-007 SHALL have: in_ready  output  1  block accepts operands this cycle.
REQ-008 SHALL have: in0  input  WIDTH  operand A; in1  input  WIDTH  operand B.
REQ-009 SHALL have: mode  input  1  0 = exact, 1 = approximate; sampled with operands.
REQ-010 SHALL have: out_valid  output  1  result valid; out_ready  input  1  consumer accepts result.
REQ-011 SHALL have: out0  output  WIDTH+1  delivered sum; err_flag  output  1  violation flag for out0.
REQ-012 SHALL have: viol_cnt  output  CNT_W  violation count; max_err  output  WIDTH+1  largest error seen.
REQ-013 SHALL have: clr  input  1  synchronous clear of viol_cnt and max_err.

Function
REQ-014 SHALL accept an operand pair on a cycle with in_valid and in_ready both high; SHALL deliver a result on a cycle with out_valid and out_ready both high.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers in0, in1 and mode; stage 2 registers out0, the exact sum and the error.
REQ-016 SHALL present a result 2 cycles after acceptance while out_ready stays high; throughput one result per cycle.
REQ-017 SHALL stall when out_valid is high and out_ready is low: out0/err_flag held stable, no stage overwritten, in_ready low once both stages are full.
REQ-018 SHALL drive in_ready = (stage 1 empty) OR (stage 1 can advance); stage 1 advances when stage 2 is empty or out_ready is high (no combinational in_valid -> in_ready path).
REQ-019 Exact mode: out0 SHALL equal in0 + in1, zero-extended to WIDTH+1.
REQ-020 Approximate mode (lower-part OR): out0[APPROX_BITS-1:0] = in0 | in1 on those bits; carry-in to the upper part = in0[APPROX_BITS-1] & in1[APPROX_BITS-1]; out0[WIDTH:APPROX_BITS] = upper in0 + upper in1 + that carry.
REQ-021 APPROX_BITS = 0 SHALL make approximate mode identical to exact mode.
REQ-022 Error SHALL be |exact sum - out0| at WIDTH+1 bits, unsigned; err_flag = (error > ET), valid with out_valid.
REQ-023 On each output handshake with err_flag high, viol_cnt SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-024 On each output handshake, max_err SHALL update to max(max_err, error).
REQ-025 clr SHALL zero viol_cnt and max_err on the next edge; clr coinciding with a handshake: clr wins, that result is not counted.
REQ-026 Mode changes SHALL affect only operands accepted after the change; in-flight results keep their sampled mode.

Reset
REQ-027 rst high SHALL asynchronously clear both stage valid bits, out0, err_flag, viol_cnt and max_err to 0; in_ready SHALL read 1 while out_valid = 0.
REQ-028 Reset mid-operation SHALL discard all in-flight results without delivering them.

Structure
REQ-029 Mode encoding (MODE_EXACT = 0, MODE_APPROX = 1) and the error-width function SHALL live in package approx_adder_pkg.
REQ-030 The combinational adder datapath SHALL be the sub-module loa_adder_core (params WIDTH, APPROX_BITS; inputs in0, in1, mode; output sum); the monitor instantiates it once and computes the exact sum separately.

Verification
REQ-031 WIDTH=2, APPROX_BITS=1, ET=0, mode=1, in0=1, in1=1 -> out0=3 two cycles later, err_flag=1, viol_cnt=1, max_err=1.
REQ-032 Same config, mode=0, in0=3, in1=3 -> out0=6, err_flag=0, counters unchanged.
REQ-033 Back-to-back pairs with out_ready held low 3 cycles -> in_ready drops after 2 accepts, out0 stable, results in order once out_ready rises, no loss or duplication.
REQ-034 CNT_W=2, ET=0, five violating handshakes -> viol_cnt saturates at 3; clr pulse -> viol_cnt=0, max_err=0; clr with a violating handshake -> viol_cnt stays 0.
REQ-035 rst asserted with both stages full -> out_valid=0, viol_cnt=0 immediately, no result delivered after release.
REQ-036 Exhaustive sweep WIDTH=4, APPROX_BITS=2, ET=5, both modes -> out0 matches REQ-019/020 model, err_flag matches REQ-022 for all 256 pairs.
